// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/bus bundle between the four mux requesters and the round-robin arbiter.
// The master side drives requests and data. The slave side (the arbiter) returns the grant, the select and the gated mux bit.
interface mux4_rr_arbiter_if #(
  parameter int CW = 4
);
  logic [3:0]    req;
  logic [3:0]    d;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          valid;
  logic          y;
  logic [CW-1:0] hold_cnt;

  modport master (
    output req, d,
    input  gnt, sel, valid, y, hold_cnt
  );

  modport slave (
    input  req, d,
    output gnt, sel, valid, y, hold_cnt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 bit mux.
// A hold limit stops one requester from monopolising the mux.
//
// state | meaning
// IDLE  | no grant; sel keeps its last value
// GRANT | exactly one gnt bit high; sel indexes the owner
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [3:0] others;
  logic [2:0] pick_all, pick_oth;
  logic       expired;
  logic       do_grant;
  logic [1:0] new_idx;

  // Returns {found, index} of the first set mask bit in the order ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    new_idx  = 2'd0;
    others   = bus.req & ~gnt_q;
    pick_all = rr_pick(ptr_q, bus.req);
    pick_oth = rr_pick(ptr_q, others);
    expired  = (HOLD_MAX != 0) && (hold_q == CW'(HOLD_MAX));

    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          do_grant = 1'b1;
          new_idx  = pick_all[1:0];
        end
      end
      GRANT: begin
        // Release wins over expiry; both hand over straight to the next competitor.
        if (!bus.req[sel_q] || expired) begin
          if (pick_oth[2]) begin
            do_grant = 1'b1;
            new_idx  = pick_oth[1:0];
          end else if (!bus.req[sel_q]) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
          end else begin
            hold_d = CW'(1);
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d = GRANT;
      sel_d   = new_idx;
      ptr_d   = new_idx;
      gnt_d   = 4'b0001 << new_idx;
      hold_d  = CW'(1);
    end
  end

  always_comb begin
    bus.gnt      = gnt_q;
    bus.sel      = sel_q;
    bus.valid    = (state_q == GRANT);
    bus.hold_cnt = hold_q;
    bus.y        = (state_q == GRANT) & bus.d[sel_q];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with hand-computed expectations,
// then random traffic compared every cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
  localparam int HM = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mux4_rr_arbiter_if #(.CW(CW)) bus ();

  mux4_rr_arbiter #(.HOLD_MAX(HM), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the mux, for how long, and who was served last.
  int m_valid, m_sel, m_ptr, m_hold;
  int m_nxt;
  logic [3:0] m_req;
  logic [3:0] m_oth;

  function automatic int next_after(input int ptr, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_sel = 0; m_ptr = 3; m_hold = 0;
    end else begin
      m_req = bus.req;
      if (m_valid == 0) begin
        m_nxt = next_after(m_ptr, m_req);
        if (m_nxt >= 0) begin
          m_valid = 1; m_sel = m_nxt; m_ptr = m_nxt; m_hold = 1;
        end
      end else begin
        m_oth = m_req;
        m_oth[m_sel] = 1'b0;
        m_nxt = next_after(m_ptr, m_oth);
        if (!m_req[m_sel] || (m_hold == HM)) begin
          if (m_nxt >= 0) begin
            m_sel = m_nxt; m_ptr = m_nxt; m_hold = 1;
          end else if (!m_req[m_sel]) begin
            m_valid = 0; m_hold = 0;
          end else begin
            m_hold = 1;
          end
        end else if (m_hold < (1 << CW) - 1) begin
          m_hold = m_hold + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int exp_gnt;
    exp_gnt = m_valid ? (1 << m_sel) : 0;
    check("gnt", int'(bus.gnt), exp_gnt);
    check("sel", int'(bus.sel), m_sel);
    check("valid", int'(bus.valid), m_valid);
    check("y", int'(bus.y), m_valid ? int'(bus.d[m_sel]) : 0);
    if (m_valid != 0) check("hold_cnt", int'(bus.hold_cnt), m_hold);
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] dv);
    bus.req = r;
    bus.d   = dv;
    #1;
    check("y_comb", int'(bus.y), m_valid ? int'(dv[m_sel]) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    bus.req = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int seq[$];
  int idle_cycles;
  logic [3:0] r;

  initial begin
    bus.req = 4'b0000;
    bus.d   = 4'b0000;

    // Reset, grant, then assert reset mid-grant.
    do_reset();
    drive(4'b0001, 4'b0001);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_sel", int'(bus.sel), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_hold", int'(bus.hold_cnt), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    drive(4'b0100, 4'b0100);
    @(negedge clk); #2;
    check("single_gnt", int'(bus.gnt), 4);
    check("single_sel", int'(bus.sel), 2);
    check("single_valid", int'(bus.valid), 1);
    check("single_y", int'(bus.y), 1);
    check("single_hold", int'(bus.hold_cnt), 1);

    // Round-robin order with each grantee dropping after two cycles.
    do_reset();
    drive(4'b1111, 4'b1010);
    idle_cycles = 0;
    seq.delete();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      if (bus.valid) begin
        if (bus.hold_cnt == CW'(1)) seq.push_back(int'(bus.sel));
      end else idle_cycles++;
      r = 4'b1111;
      if (m_valid != 0 && m_hold == 2) r[m_sel] = 1'b0;
      drive(r, 4'($urandom));
    end
    check("rr_count", seq.size(), 5);
    check("rr_idle", idle_cycles, 0);
    for (int i = 0; i < 5 && i < seq.size(); i++) check("rr_order", seq[i], i % 4);

    // Hold expiry with two competitors.
    do_reset();
    drive(4'b0011, 4'b0001);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #2;
      check("exp_sel", int'(bus.sel), ((k - 1) / 8) % 2);
      check("exp_hold", int'(bus.hold_cnt), (k - 1) % 8 + 1);
    end

    // Expiry with no competitor wraps hold_cnt.
    do_reset();
    drive(4'b0001, 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #2;
      check("solo_gnt", int'(bus.gnt), 1);
      check("solo_hold", int'(bus.hold_cnt), (k - 1) % 8 + 1);
    end

    // Simultaneous release and expiry on requester 2, then release to idle.
    do_reset();
    drive(4'b0100, 4'b0000);
    repeat (7) @(negedge clk);
    #1 drive(4'b0110, 4'b0000);
    @(negedge clk); #2;
    check("sim_pre_sel", int'(bus.sel), 2);
    check("sim_pre_hold", int'(bus.hold_cnt), 8);
    drive(4'b0010, 4'b0000);
    @(negedge clk); #2;
    check("sim_gnt", int'(bus.gnt), 2);
    check("sim_valid", int'(bus.valid), 1);
    check("sim_hold", int'(bus.hold_cnt), 1);
    drive(4'b0000, 4'b1111);
    @(negedge clk); #2;
    check("idle_valid", int'(bus.valid), 0);
    check("idle_gnt", int'(bus.gnt), 0);
    check("idle_y", int'(bus.y), 0);
    check("idle_sel", int'(bus.sel), 1);

    // Random traffic; sparse bit flips keep requests alive long enough to expire.
    do_reset();
    r = 4'b0000;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      r = r ^ 4'($urandom & $urandom & $urandom);
      drive(r, 4'($urandom));
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select sequencer for the 4:1 data multiplexer. Four requesters compete for the single mux output. The block issues a one-hot grant, drives the 2-bit mux select, and gates the muxed bit onto a qualified output. A hold limit prevents one requester from monopolising the mux.

## Interface

Parameters:
- `HOLD_MAX`, default 8: maximum consecutive cycles a grant is held while other requesters wait; 0 = unlimited.
- `CW`, default 4: hold counter width; must satisfy `2^CW > HOLD_MAX`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input [3:0]: request, one bit per requester; level-sensitive and held while the requester wants the mux.
- `d` input [3:0]: data bit from each requester; `d[i]` belongs to requester i.
- `gnt` output [3:0]: one-hot grant, registered; all zero when idle.
- `sel` output [1:0]: mux select, registered; index of the granted requester.
- `valid` output 1: registered; high while any grant is active.
- `y` output 1: `d[sel]` when `valid`, else 0; combinational from the registered `sel`/`valid` and live `d`.
- `hold_cnt` output [CW-1:0]: cycles the current grant has been held, registered.

## Operation

- States: IDLE (no grant) and GRANT (exactly one `gnt` bit high).
- Priority pointer `ptr` [1:0] holds the last granted index.
  - Search order is `ptr+1`, `ptr+2`, `ptr+3`, `ptr`, modulo 4.
  - `ptr` updates to the new index on every new grant.
- IDLE:
  - If `req`==0, remain in IDLE.
  - Otherwise grant the first requesting index in search order and go to GRANT.
  - `hold_cnt` is set to 1 on the grant.
- GRANT, evaluated each edge with g = `sel`:
  - **Release:** `req[g]`==0. If other requests are present, grant the next in search order directly, with no idle bubble. If none are present, go to IDLE, with `gnt`=0, `valid`=0, and `sel` holding its last value.
  - **Expiry:** `HOLD_MAX`≠0 and `hold_cnt`==`HOLD_MAX` and any other `req` bit is high. Revoke g and grant the next requester among `ptr+1..ptr+3` in search order. The same edge as the last held cycle is used.
  - **Expiry with no competitor:** keep the grant and reset `hold_cnt` to 1.
  - **Otherwise:** keep the grant; `hold_cnt` increments and saturates at `2^CW-1` when `HOLD_MAX`=0.
- Release takes precedence over expiry when both occur on the same edge.
- Every new grant, including back-to-back, loads `hold_cnt`=1.
- `gnt` is always `1<<sel` when `valid`=1, else 0.

## Timing

- Reset values (async assert, sync release): `gnt`=0, `sel`=0, `valid`=0, `hold_cnt`=0, `ptr`=3 (requester 0 highest priority first), state IDLE. `y`=0 follows from `valid`=0.
- Latency: `req` rising at edge N is sampled at edge N+1. `gnt`/`sel`/`valid` are visible after edge N+1.
- Release latency: dropping `req[g]` before edge M removes the grant at edge M.
- Handover: the new grant is visible in the same cycle the old grant drops. There is never a cycle with two grant bits set.
- With `HOLD_MAX`=H and continuous competition, each requester holds for exactly H cycles.
- `y` has zero added latency from `d`; it is a purely combinational path through the mux.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock. After release, arbitration restarts from `ptr`=3.
- Requests that appear and vanish between edges are never seen.

## Test plan

- **Reset and single request.**
  - Stimulus: assert `rst_n`=0 mid-grant.
  - Response: all outputs are 0 immediately.
  - Stimulus: release reset, then `req`=4'b0100, `d`=4'b0100.
  - Response: one edge later `gnt`=4'b0100, `sel`=2, `valid`=1, `y`=1, `hold_cnt`=1.
- **Round-robin order.**
  - Stimulus: `req`=4'b1111 held, with each grantee dropping its request after 2 cycles and re-raising it.
  - Response: the grant sequence is 0,1,2,3,0 with no idle cycles between grants.
- **Hold expiry.**
  - Stimulus: `HOLD_MAX`=8, `req`=4'b0011 held continuously.
  - Response: requester 0 holds for 8 cycles (`hold_cnt` 1..8), then requester 1 for 8, and so on.
- **Expiry without competitor.**
  - Stimulus: `req`=4'b0001 only, for 20 cycles.
  - Response: the grant stays on 0; `hold_cnt` wraps 8 to 1.
- **Simultaneous release and expiry.**
  - Stimulus: with requester 2 at `hold_cnt`=8 and `req`=4'b0110, drop `req[2]` on that edge.
  - Response: requester 1 is granted next. No IDLE cycle occurs and no double grant.
- **Release to idle and data gating.**
  - Stimulus: drop the only request.
  - Response: next edge `valid`=0, `gnt`=0, and `y`=0 regardless of `d`=4'b1111.
